adc_conv_sequencer: RTL

ADC_CONV_SEQUENCER -- requirements
Module: adc_conv_sequencer

---
 rtl/adc_conv_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/adc_conv_sequencer.sv
// Conversion sequencer for an external ADC: issues start pulses on trigger or on a
// periodic timer, waits for the (asynchronous) done strobe and queues results in a FWFT FIFO.
module adc_conv_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int START_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_enable_in,
  input  logic                          cfg_continuous_in,
  input  logic [15:0]                   cfg_period_in,
  input  logic [15:0]                   cfg_timeout_in,
  input  logic                          trigger_in,
  output logic                          start_conversion_out,
  input  logic                          conversion_finished_in,
  input  logic [15:0]                   result_in,
  input  logic                          rd_en_in,
  output logic [15:0]                   rd_data_out,
  output logic                          fifo_empty_out,
  output logic                          fifo_full_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          overflow_out,
  output logic                          timeout_out,
  input  logic                          clear_flags_in,
  output logic                          busy_out
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int SC_W   = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_CAPTURE
  } state_e;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   start_cnt_q, start_cnt_d;
  logic [15:0]       period_cnt_q, period_cnt_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  logic              fin_meta_q, fin_sync_q, fin_prev_q;
  logic              done_edge;
  logic              tmo_hit;
  logic              capture;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              fifo_full, fifo_empty;
  logic              rd_ok, wr_ok, ovf_set;

  assign done_edge = fin_sync_q & ~fin_prev_q;

  // The period counter is loaded with period-1 so that, counting the START entry
  // cycle itself, consecutive starts land exactly cfg_period_in cycles apart.
  always_comb begin
    state_d      = state_q;
    start_cnt_d  = start_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    period_cnt_d = (period_cnt_q != 16'd0) ? period_cnt_q - 16'd1 : 16'd0;
    tmo_hit      = 1'b0;
    capture      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_enable_in &&
            (trigger_in || (cfg_continuous_in && (period_cnt_q == 16'd0)))) begin
          state_d      = S_START;
          start_cnt_d  = '0;
          period_cnt_d = (cfg_period_in != 16'd0) ? cfg_period_in - 16'd1 : 16'd0;
        end
      end
      S_START: begin
        if (start_cnt_q == SC_W'(START_CYCLES - 1)) begin
          state_d   = S_WAIT_DONE;
          tmo_cnt_d = '0;
        end else begin
          start_cnt_d = start_cnt_q + SC_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (done_edge) begin
          state_d = S_CAPTURE;
        end else if ((cfg_timeout_in != 16'd0) &&
                     ((17'(tmo_cnt_q) + 17'd1) >= 17'(cfg_timeout_in))) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);

  // A read frees the slot in the same cycle, so a full FIFO still accepts a capture then.
  always_comb begin
    rd_ok    = rd_en_in & ~fifo_empty;
    wr_ok    = capture & (~fifo_full | rd_ok);
    ovf_set  = capture & fifo_full & ~rd_ok;
    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    overflow_d = ovf_set | (overflow_q & ~clear_flags_in);
    timeout_d  = tmo_hit | (timeout_q & ~clear_flags_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_cnt_q  <= '0;
      period_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      fin_meta_q   <= 1'b0;
      fin_sync_q   <= 1'b0;
      fin_prev_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_cnt_q  <= start_cnt_d;
      period_cnt_q <= period_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      fin_meta_q   <= conversion_finished_in;
      fin_sync_q   <= fin_meta_q;
      fin_prev_q   <= fin_sync_q;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
    end
  end

  // Storage is data only; validity comes from the reset pointers and level.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= result_in;
    end
  end

  assign start_conversion_out = (state_q == S_START);
  assign busy_out             = (state_q != S_IDLE);
  assign rd_data_out          = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_empty_out       = fifo_empty;
  assign fifo_full_out        = fifo_full;
  assign fifo_level_out       = level_q;
  assign overflow_out         = overflow_q;
  assign timeout_out          = timeout_q;

endmodule
